// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush to a NOP pattern and a saturating stall-cycle counter.
module pipe_stage_reg #(
   parameter int unsigned       DATA_W    = 96,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
   parameter bit                SKID_EN   = 1'b1,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic              i_flush,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            r_state;
   state_t            w_state_next;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic [DATA_W-1:0] w_main_next;
   logic [DATA_W-1:0] w_skid_next;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              w_acc;
   logic              w_emt;

   assign o_out_valid = (r_state != ST_EMPTY);
   assign o_out_data  = r_main;
   assign o_stall_cnt = r_stall_cnt;
   assign w_acc       = i_in_valid & o_in_ready;
   assign w_emt       = o_out_valid & i_out_ready;

   always_comb begin
      w_state_next = r_state;
      w_main_next  = r_main;
      w_skid_next  = r_skid;
      case (r_state)
         ST_EMPTY: begin
            if (w_acc) begin
               w_state_next = ST_FULL;
               w_main_next  = i_in_data;
            end
         end
         ST_FULL: begin
            if (w_acc && w_emt) begin
               w_main_next = i_in_data;
            end else if (w_emt) begin
               // Drained stage reads as a NOP bubble rather than stale data.
               w_state_next = ST_EMPTY;
               w_main_next  = CLEAR_VAL;
            end else if (w_acc && SKID_EN) begin
               w_state_next = ST_SKID;
               w_skid_next  = i_in_data;
            end
         end
         ST_SKID: begin
            if (w_emt) begin
               w_state_next = ST_FULL;
               w_main_next  = r_skid;
               w_skid_next  = CLEAR_VAL;
            end
         end
         default: begin
            w_state_next = ST_EMPTY;
            w_main_next  = CLEAR_VAL;
            w_skid_next  = CLEAR_VAL;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         r_state <= ST_EMPTY;
         r_main  <= CLEAR_VAL;
         r_skid  <= CLEAR_VAL;
      end else begin
         r_state <= w_state_next;
         r_main  <= w_main_next;
         r_skid  <= w_skid_next;
      end
   end

   // Flush deliberately leaves the stall history intact.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_stall_cnt <= '0;
      end else if (o_out_valid && !i_out_ready && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   generate
      if (SKID_EN) begin : g_skid
         logic r_in_ready;
         // Registered ready: upstream never sees a combinational path from i_out_ready.
         always_ff @(posedge i_clk) begin
            if (!i_rst_n || i_flush) begin
               r_in_ready <= 1'b1;
            end else begin
               r_in_ready <= (w_state_next != ST_SKID);
            end
         end
         assign o_in_ready = r_in_ready;
      end else begin : g_noskid
         assign o_in_ready = !o_out_valid | i_out_ready;
      end
   endgenerate

endmodule
